// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block.
// Segment patterns are {a,b,c,d,e,f,g}, where a is bit 6.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h7E;
  localparam logic [6:0] SEG7_1     = 7'h30;
  localparam logic [6:0] SEG7_2     = 7'h6D;
  localparam logic [6:0] SEG7_3     = 7'h79;
  localparam logic [6:0] SEG7_4     = 7'h33;
  localparam logic [6:0] SEG7_5     = 7'h5B;
  localparam logic [6:0] SEG7_6     = 7'h5F;
  localparam logic [6:0] SEG7_6_ALT = 7'h1F;
  localparam logic [6:0] SEG7_7     = 7'h70;
  localparam logic [6:0] SEG7_7_ALT = 7'h72;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h7B;
  localparam logic [6:0] SEG7_9_ALT = 7'h73;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hF;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder.
// Alternate glyphs for 6, 7 and 9 are accepted.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);

  always_comb begin
    bcd   = BCD_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (seg_in)
      SEG7_0:                 bcd = 4'd0;
      SEG7_1:                 bcd = 4'd1;
      SEG7_2:                 bcd = 4'd2;
      SEG7_3:                 bcd = 4'd3;
      SEG7_4:                 bcd = 4'd4;
      SEG7_5:                 bcd = 4'd5;
      SEG7_6, SEG7_6_ALT:     bcd = 4'd6;
      SEG7_7, SEG7_7_ALT:     bcd = 4'd7;
      SEG7_8:                 bcd = 4'd8;
      SEG7_9, SEG7_9_ALT:     bcd = 4'd9;
      SEG7_BLANK: begin
        bcd   = BCD_BLANK;
        blank = 1'b1;
      end
      default: begin
        bcd = BCD_ERR;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment bus. It debounces each digit window,
// decodes the segment pattern to BCD and presents complete frames on a valid/ready port.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]              state, state_next;
  logic [NUM_DIGITS-1:0]   prev_dig;
  logic [6:0]              prev_seg;
  logic                    in_window;
  logic                    captured;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [NUM_DIGITS-1:0]   cap_mask, cap_mask_next;
  logic [4*NUM_DIGITS-1:0] work_bcd;
  logic [NUM_DIGITS-1:0]   work_blank;
  logic [NUM_DIGITS-1:0]   work_err;

  logic       one_hot;
  logic       first;
  logic       capture;
  logic       captured_next;
  logic       frame_done;
  logic       xfer;
  logic       load;
  logic       drop;
  logic [3:0] dec_bcd;
  logic       dec_blank;
  logic       dec_err;
  decode_t    dec;

  // One decoder serves all digits because only one digit is enabled per cycle.
  seg7_pattern_decode u_decode (
    .seg_in (seg_in),
    .bcd    (dec_bcd),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  assign dec = '{bcd: dec_bcd, blank: dec_blank, err: dec_err};

  assign one_hot = (dig_en != '0) && ((dig_en & (dig_en - 1'b1)) == '0);
  assign first   = one_hot && (!in_window || (dig_en != prev_dig));

  always_comb begin
    cnt_next = '0;
    if (one_hot) begin
      if (first || (seg_in != prev_seg)) begin
        cnt_next = CNT_W'(1);
      end else if (cnt == CNT_MAX) begin
        cnt_next = cnt;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // The captured flag from an earlier window is ignored on the first cycle of a new one.
  assign capture       = one_hot && (cnt_next == CNT_MAX) && (first || !captured);
  assign captured_next = one_hot && (capture || (!first && captured));

  assign frame_done    = &cap_mask;
  assign cap_mask_next = (frame_done ? '0 : cap_mask) | (capture ? dig_en : '0);

  assign out_valid = (state == ST_PRESENT);
  assign xfer      = out_valid && out_ready;
  assign load      = frame_done && (!out_valid || out_ready);
  assign drop      = frame_done && out_valid && !out_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: if (load)          state_next = ST_PRESENT;
      ST_PRESENT: if (xfer && !load) state_next = ST_COLLECT;
      default:                       state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_dig  <= '0;
      prev_seg  <= '0;
      in_window <= 1'b0;
      captured  <= 1'b0;
      cnt       <= '0;
    end else begin
      prev_dig  <= dig_en;
      prev_seg  <= seg_in;
      in_window <= one_hot;
      captured  <= captured_next;
      cnt       <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_mask   <= '0;
      work_bcd   <= '0;
      work_blank <= '0;
      work_err   <= '0;
    end else begin
      cap_mask <= cap_mask_next;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture && dig_en[i]) begin
          work_bcd[4*i +: 4] <= dec.bcd;
          work_blank[i]      <= dec.blank;
          work_err[i]        <= dec.err;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      bcd_out   <= '0;
      blank_out <= '0;
      err_out   <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        bcd_out   <= work_bcd;
        blank_out <= work_blank;
        err_out   <= work_err;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (xfer) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture.
// Each task drives one scenario and checks the results against hand-computed values.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] bcd_out;
  logic [3:0]  blank_out;
  logic [3:0]  err_out;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  int          xfer_cnt   = 0;
  logic [15:0] xfer_bcd   = '0;
  logic [3:0]  xfer_blank = '0;
  logic [3:0]  xfer_err   = '0;

  always #5 clk = ~clk;

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .bcd_out   (bcd_out),
    .blank_out (blank_out),
    .err_out   (err_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  // Record every accepted snapshot.
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      xfer_cnt   <= xfer_cnt + 1;
      xfer_bcd   <= bcd_out;
      xfer_blank <= blank_out;
      xfer_err   <= err_out;
    end
  end

  task automatic scan(input logic [3:0] en, input logic [6:0] seg, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      dig_en = en;
      seg_in = seg;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      dig_en = 4'h0;
      seg_in = 7'h00;
    end
  endtask

  task automatic scan4(input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0);
    scan(4'h8, s3, 8);
    scan(4'h4, s2, 8);
    scan(4'h2, s1, 8);
    scan(4'h1, s0, 8);
  endtask

  task automatic test_reset;
    rst_n     = 1'b1;
    dig_en    = 4'h0;
    seg_in    = 7'h00;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seg_in    = 7'($urandom);
      dig_en    = 4'($urandom);
      out_ready = 1'($urandom);
    end
    #1;
    tests++;
    if ({bcd_out, blank_out, err_out, out_valid, overrun} !== 26'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bcd_out, blank_out, err_out, out_valid, overrun});
    end
    @(negedge clk);
    dig_en    = 4'h0;
    seg_in    = 7'h00;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    idle(6);
    tests++;
    if ({bcd_out, blank_out, err_out, out_valid, overrun} !== 26'h0) begin
      fails++;
      $display("FAIL post_reset_idle: got %h expected 0",
               {bcd_out, blank_out, err_out, out_valid, overrun});
    end
  endtask

  task automatic test_scan;
    int base;
    base = xfer_cnt;
    out_ready = 1'b1;
    scan4(7'h30, 7'h6D, 7'h79, 7'h33);
    idle(4);
    tests++;
    if (xfer_cnt - base !== 1) begin
      fails++;
      $display("FAIL scan_xfer_count: got %0d expected 1", xfer_cnt - base);
    end
    tests++;
    if (xfer_bcd !== 16'h1234) begin
      fails++;
      $display("FAIL scan_bcd: got %h expected 1234", xfer_bcd);
    end
    tests++;
    if ({xfer_err, xfer_blank} !== 8'h00) begin
      fails++;
      $display("FAIL scan_err_blank: got %h expected 00", {xfer_err, xfer_blank});
    end
    tests++;
    if ({out_valid, overrun} !== 2'b00) begin
      fails++;
      $display("FAIL scan_valid_after: got %b expected 00", {out_valid, overrun});
    end
  endtask

  task automatic test_glitch;
    int base;
    base = xfer_cnt;
    scan(4'h8, 7'h33, 8);
    scan(4'h4, 7'h5B, 8);
    scan(4'h2, 7'h7E, 8);
    scan(4'h1, 7'h7F, 2);
    scan(4'h1, 7'h30, 6);
    idle(4);
    tests++;
    if (xfer_cnt - base !== 1 || xfer_bcd !== 16'h4501) begin
      fails++;
      $display("FAIL glitch_bcd: got %h (xfers %0d) expected 4501 (xfers 1)",
               xfer_bcd, xfer_cnt - base);
    end
    base = xfer_cnt;
    scan(4'h8, 7'h6D, 3);
    scan(4'h4, 7'h6D, 3);
    scan(4'h2, 7'h6D, 3);
    scan(4'h1, 7'h6D, 3);
    idle(4);
    tests++;
    if (out_valid !== 1'b0 || xfer_cnt !== base) begin
      fails++;
      $display("FAIL short_window: got valid=%b xfers=%0d expected valid=0 xfers=0",
               out_valid, xfer_cnt - base);
    end
  endtask

  task automatic test_patterns;
    int base;
    base = xfer_cnt;
    scan4(7'h1F, 7'h01, 7'h00, 7'h73);
    idle(4);
    tests++;
    if (xfer_cnt - base !== 1 || xfer_bcd !== 16'h6FF9) begin
      fails++;
      $display("FAIL pattern_bcd: got %h (xfers %0d) expected 6ff9 (xfers 1)",
               xfer_bcd, xfer_cnt - base);
    end
    tests++;
    if (xfer_err !== 4'b0100 || err_out !== 4'b0100) begin
      fails++;
      $display("FAIL pattern_err: got %b/%b expected 0100", xfer_err, err_out);
    end
    tests++;
    if (xfer_blank !== 4'b0010 || blank_out !== 4'b0010) begin
      fails++;
      $display("FAIL pattern_blank: got %b/%b expected 0010", xfer_blank, blank_out);
    end
  endtask

  task automatic test_backpressure;
    int base;
    base = xfer_cnt;
    out_ready = 1'b0;
    scan4(7'h30, 7'h6D, 7'h79, 7'h33);
    idle(2);
    tests++;
    if ({out_valid, overrun} !== 2'b10 || bcd_out !== 16'h1234) begin
      fails++;
      $display("FAIL bp_first_frame: got v/o=%b bcd=%h expected 10 1234",
               {out_valid, overrun}, bcd_out);
    end
    scan4(7'h5B, 7'h5F, 7'h70, 7'h7F);
    idle(2);
    tests++;
    if ({out_valid, overrun} !== 2'b11 || bcd_out !== 16'h1234) begin
      fails++;
      $display("FAIL bp_drop: got v/o=%b bcd=%h expected 11 1234",
               {out_valid, overrun}, bcd_out);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, overrun} !== 2'b00 || xfer_cnt - base !== 1 || xfer_bcd !== 16'h1234) begin
      fails++;
      $display("FAIL bp_release: got v/o=%b xfers=%0d bcd=%h expected 00 1 1234",
               {out_valid, overrun}, xfer_cnt - base, xfer_bcd);
    end
    scan(4'h8, 7'h7B, 8);
    scan(4'h4, 7'h7F, 8);
    scan(4'h2, 7'h72, 8);
    scan(4'h3, 7'h7E, 8);
    idle(3);
    tests++;
    if (out_valid !== 1'b0 || xfer_cnt - base !== 1) begin
      fails++;
      $display("FAIL multi_hot: got valid=%b xfers=%0d expected 0 1",
               out_valid, xfer_cnt - base);
    end
    scan(4'h1, 7'h7E, 8);
    idle(3);
    tests++;
    if (xfer_cnt - base !== 2 || xfer_bcd !== 16'h9870) begin
      fails++;
      $display("FAIL multi_hot_complete: got xfers=%0d bcd=%h expected 2 9870",
               xfer_cnt - base, xfer_bcd);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    out_ready = 1'b1;
    scan(4'h8, 7'h30, 8);
    scan(4'h4, 7'h6D, 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bcd_out, blank_out, err_out, out_valid, overrun} !== 26'h0) begin
      fails++;
      $display("FAIL async_reset: got %h expected 0",
               {bcd_out, blank_out, err_out, out_valid, overrun});
    end
    @(negedge clk);
    rst_n  = 1'b1;
    dig_en = 4'h0;
    base   = xfer_cnt;
    scan(4'h2, 7'h79, 8);
    scan(4'h1, 7'h33, 8);
    idle(3);
    tests++;
    if (out_valid !== 1'b0 || xfer_cnt !== base) begin
      fails++;
      $display("FAIL partial_discard: got valid=%b xfers=%0d expected 0 0",
               out_valid, xfer_cnt - base);
    end
    scan(4'h8, 7'h5B, 8);
    scan(4'h4, 7'h5F, 8);
    idle(3);
    tests++;
    if (xfer_cnt - base !== 1 || xfer_bcd !== 16'h5634) begin
      fails++;
      $display("FAIL post_reset_frame: got xfers=%0d bcd=%h expected 1 5634",
               xfer_cnt - base, xfer_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_patterns();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
